// File: rtl/uart_rx_fifo_if.sv
// Valid/ready character stream between the UART receiver FIFO and its consumer.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_err, output m_valid, input m_ready);
  modport slave  (input m_data, input m_err, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling with 3-sample majority vote, configurable frame
// format, framing/parity/overrun detection and a valid/ready output FIFO.
module uart_rx_fifo #(
  parameter int CLK_DIV        = 260,
  parameter int DIV_WIDTH      = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_LOG_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx,
  uart_rx_fifo_if.master          m,
  output logic                    frame_err,
  output logic                    overrun,
  output logic [FIFO_LOG_DEPTH:0] fifo_count
);

  localparam int                      DEPTH    = 1 << FIFO_LOG_DEPTH;
  localparam logic [DIV_WIDTH-1:0]    DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [DIV_WIDTH-1:0]    DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [3:0]              BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic                    ODD      = (PARITY == 1);
  localparam logic [FIFO_LOG_DEPTH:0] CNT_ONE  = (FIFO_LOG_DEPTH+1)'(1);
  localparam logic [FIFO_LOG_DEPTH:0] CNT_FULL = (FIFO_LOG_DEPTH+1)'(DEPTH);
  localparam logic [FIFO_LOG_DEPTH-1:0] PTR_ONE = FIFO_LOG_DEPTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_BRK
  } state_e;

  logic rx_meta_q, rx_s_q;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [3:0]             ph_q, ph_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   push;
  logic                   tick, decide, bit_end, maj;

  assign tick    = (div_q == DIV_LAST);
  assign decide  = tick && (ph_q == 4'd9);
  assign bit_end = tick && (ph_q == 4'd15);
  // The ph=9 sample is the live rx_s, so the vote resolves on the decision tick itself.
  assign maj     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIV_ONE;
    ph_d        = tick ? ph_q + 4'd1 : ph_q;
    s7_d        = (tick && ph_q == 4'd7) ? rx_s_q : s7_q;
    s8_d        = (tick && ph_q == 4'd8) ? rx_s_q : s8_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          div_d     = '0;
          ph_d      = '0;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (decide && maj) state_d = S_IDLE;
        else if (bit_end)  state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                       bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (decide)  par_err_d = (((^shift_q) ^ maj) != ODD);
        if (bit_end) state_d   = S_STOP;
      end
      S_STOP, S_STOP2: begin
        // Leave at the decision tick rather than ph=15 to absorb transmitter clock skew.
        if (decide) begin
          if (!maj) begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end else if (state_q == S_STOP2 || STOP_BITS == 1) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          state_d = S_STOP2;
        end
      end
      S_BRK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      ph_q        <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  logic [DATA_BITS:0]        mem_q [DEPTH];
  logic [FIFO_LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG_DEPTH:0]   count_q, count_d;
  logic                      valid_q, overrun_q;
  logic                      pop, full, wr_en;

  assign pop   = valid_q && m.m_ready;
  assign full  = (count_q == CNT_FULL);
  // When full, a same-cycle pop frees the slot; wr_ptr then equals rd_ptr and the
  // head being popped is the entry overwritten.
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_ONE;
    else if (!wr_en && pop) count_d = count_q - CNT_ONE;
  end

  // NOTE: FIFO storage is reset (unusual for memories) because the head entry is
  // driven straight onto m_data, which must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {par_err_q, shift_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
      overrun_q <= push && full && !pop;
    end
  end

  assign m.m_data   = mem_q[rd_ptr_q][DATA_BITS-1:0];
  assign m.m_err    = mem_q[rd_ptr_q][DATA_BITS];
  assign m.m_valid  = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: three receiver configurations (8N1/depth 8, 7E1, 8N1/depth 4)
// driven with directed and random frames, checked against a frame-level model.
module tb_uart_rx_fifo;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;
  // Push edge of an 8N1 frame counted from the slot the start bit is driven:
  // 2 sync flops + 1 detect clk, CLK_DIV clks to the first tick, then 153 ticks.
  localparam int PUSH_SLOT = 3 + CLK_DIV * (1 + 16 * 9 + 9);

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic fe_a, fe_b, fe_c, ov_a, ov_b, ov_c;
  logic [3:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(7)) if_b ();
  uart_rx_fifo_if #(.DATA_BITS(8)) if_c ();

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(16), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_LOG_DEPTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a), .m(if_a),
    .frame_err(fe_a), .overrun(ov_a), .fifo_count(cnt_a));

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(16), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_LOG_DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_b), .m(if_b),
    .frame_err(fe_b), .overrun(ov_b), .fifo_count(cnt_b));

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(16), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_LOG_DEPTH(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_c), .m(if_c),
    .frame_err(fe_c), .overrun(ov_c), .fifo_count(cnt_c));

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected characters, {parity_err, data}, in delivery order per receiver.
  logic [31:0] exp_a[$], exp_b[$], exp_c[$];

  always @(negedge clk) begin
    if (if_a.m_valid && if_a.m_ready) begin
      if (exp_a.size() == 0) check("a_pop_unexpected", {if_a.m_err, if_a.m_data}, 32'hFFFF);
      else check("a_pop", {if_a.m_err, if_a.m_data}, exp_a.pop_front());
    end
    if (if_b.m_valid && if_b.m_ready) begin
      if (exp_b.size() == 0) check("b_pop_unexpected", {if_b.m_err, if_b.m_data}, 32'hFFFF);
      else check("b_pop", {if_b.m_err, if_b.m_data}, exp_b.pop_front());
    end
    if (if_c.m_valid && if_c.m_ready) begin
      if (exp_c.size() == 0) check("c_pop_unexpected", {if_c.m_err, if_c.m_data}, 32'hFFFF);
      else check("c_pop", {if_c.m_err, if_c.m_data}, exp_c.pop_front());
    end
  end

  // Pulse counters: 0 fe_a, 1 ov_a, 2 fe_b, 3 ov_b, 4 fe_c, 5 ov_c.
  logic [5:0] flags;
  logic [5:0] flags_prev = '0;
  int pulse_cnt [6];
  int long_pulse = 0;
  assign flags = {ov_c, fe_c, ov_b, fe_b, ov_a, fe_a};

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (flags[i]) pulse_cnt[i]++;
      if (flags[i] && flags_prev[i]) long_pulse++;
    end
    flags_prev <= flags;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int line, input logic v);
    case (line)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int line, input int n);
    set_line(line, 1'b1);
    repeat (n) step();
  endtask

  // Frame as seen on the line: start 0, data LSB first, optional parity, one stop.
  function automatic void make_frame(input logic [8:0] data, input int dbits, input int parity,
                                     input bit flip_par, input bit stop_low,
                                     output logic [15:0] bits, output int n);
    int   ones;
    logic p;
    bits    = '1;
    bits[0] = 1'b0;
    ones    = 0;
    for (int i = 0; i < dbits; i++) begin
      bits[1+i] = data[i];
      if (data[i]) ones++;
    end
    n = 1 + dbits;
    if (parity != 0) begin
      p = (parity == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
      bits[n] = p ^ flip_par;
      n++;
    end
    bits[n] = !stop_low;
    n++;
  endfunction

  // spike_bit >= 0 pulls the line low for one tick around that bit's ph=8 sample.
  task automatic send_char(input int line, input logic [8:0] data, input int dbits,
                           input int parity, input bit flip_par, input bit stop_low,
                           input int spike_bit);
    logic [15:0] bits;
    int          n;
    make_frame(data, dbits, parity, flip_par, stop_low, bits, n);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < BIT_CLKS; c++) begin
        set_line(line, (b == spike_bit && c >= 34 && c <= 37) ? 1'b0 : bits[b]);
        step();
      end
  endtask

  initial begin
    logic [31:0] snap;
    int          unstable;
    int          fe_base, ov_base;
    bit          done;
    logic [7:0]  d;

    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    if_a.m_ready = 1'b0; if_b.m_ready = 1'b0; if_c.m_ready = 1'b0;
    repeat (3) step();

    check("a_reset", {if_a.m_valid, if_a.m_err, if_a.m_data, cnt_a, fe_a, ov_a}, 0);
    check("b_reset", {if_b.m_valid, if_b.m_err, if_b.m_data, cnt_b, fe_b, ov_b}, 0);
    check("c_reset", {if_c.m_valid, if_c.m_err, if_c.m_data, cnt_c, fe_c, ov_c}, 0);
    rst_n = 1'b1;
    repeat (20) step();

    // 8N1 single frame held without ready, then one pop.
    exp_a.push_back(32'h0A5);
    send_char(0, 9'h0A5, 8, 0, 1'b0, 1'b0, -1);
    idle(0, 20);
    check("t1_valid", if_a.m_valid, 1);
    check("t1_data", if_a.m_data, 8'hA5);
    check("t1_err", if_a.m_err, 0);
    check("t1_count", cnt_a, 1);
    snap = {if_a.m_valid, if_a.m_err, if_a.m_data, cnt_a};
    unstable = 0;
    repeat (100) begin
      step();
      if ({if_a.m_valid, if_a.m_err, if_a.m_data, cnt_a} !== snap) unstable++;
    end
    check("t1_stable", unstable, 0);
    if_a.m_ready = 1'b1;
    step();
    if_a.m_ready = 1'b0;
    step();
    check("t1_count_after_pop", cnt_a, 0);
    check("t1_valid_after_pop", if_a.m_valid, 0);

    // Glitch rejection: 2-tick start glitch, then a voted-out spike inside 0xFF.
    set_line(0, 1'b0);
    repeat (2 * CLK_DIV) step();
    idle(0, 700);
    check("t2_glitch_count", cnt_a, 0);
    check("t2_glitch_fe", pulse_cnt[0], 0);
    exp_a.push_back(32'h0FF);
    send_char(0, 9'h0FF, 8, 0, 1'b0, 1'b0, 4);
    idle(0, 20);
    check("t2_spike_count", cnt_a, 1);
    check("t2_spike_fe", pulse_cnt[0], 0);
    if_a.m_ready = 1'b1;
    step();
    if_a.m_ready = 1'b0;
    step();

    // Framing error followed by a 3-frame break, then a clean character.
    fe_base = pulse_cnt[0];
    send_char(0, 9'h03C, 8, 0, 1'b0, 1'b1, -1);
    set_line(0, 1'b0);
    repeat (30 * BIT_CLKS) step();
    check("t4_break_count", cnt_a, 0);
    idle(0, 3 * BIT_CLKS);
    check("t4_fe_pulses", pulse_cnt[0] - fe_base, 1);
    check("t4_no_push", cnt_a, 0);
    exp_a.push_back(32'h012);
    send_char(0, 9'h012, 8, 0, 1'b0, 1'b0, -1);
    idle(0, 20);
    check("t4_count", cnt_a, 1);
    if_a.m_ready = 1'b1;
    step();
    if_a.m_ready = 1'b0;
    step();

    // Random characters and gaps with a randomly stalling consumer.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          d = 8'($urandom);
          exp_a.push_back({24'h0, d});
          send_char(0, {1'b0, d}, 8, 0, 1'b0, 1'b0, -1);
          idle(0, $urandom_range(0, 40));
        end
        idle(0, 20);
        done = 1'b1;
      end
      begin
        while (!done) begin
          if_a.m_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    if_a.m_ready = 1'b1;
    repeat (20) step();
    if_a.m_ready = 1'b0;
    check("rand_drained", exp_a.size(), 0);
    check("rand_count", cnt_a, 0);

    // 7E1: correct parity, then flipped parity, back-to-back.
    exp_b.push_back(32'h041);
    send_char(1, 9'h041, 7, 2, 1'b0, 1'b0, -1);
    exp_b.push_back(32'h0C1);
    send_char(1, 9'h041, 7, 2, 1'b1, 1'b0, -1);
    idle(1, 20);
    check("t3_count", cnt_b, 2);
    check("t3_fe", pulse_cnt[2], 0);
    if_b.m_ready = 1'b1;
    repeat (5) step();
    if_b.m_ready = 1'b0;
    check("t3_drained", exp_b.size(), 0);
    check("t3_count_after", cnt_b, 0);

    // Overrun on a depth-4 FIFO with the consumer stalled.
    ov_base = pulse_cnt[5];
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_c.push_back(32'(k));
      send_char(2, 9'(k), 8, 0, 1'b0, 1'b0, -1);
    end
    idle(2, 20);
    check("t5_count", cnt_c, 4);
    check("t5_overrun", pulse_cnt[5] - ov_base, 1);
    if_c.m_ready = 1'b1;
    repeat (6) step();
    if_c.m_ready = 1'b0;
    check("t5_drained", exp_c.size(), 0);
    check("t5_count_after", cnt_c, 0);

    // Full FIFO with a pop on the same clk as the fifth push.
    ov_base = pulse_cnt[5];
    for (int k = 0; k < 4; k++) begin
      exp_c.push_back(32'h11 + 32'(k));
      send_char(2, 9'h11 + 9'(k), 8, 0, 1'b0, 1'b0, -1);
    end
    exp_c.push_back(32'h15);
    fork
      send_char(2, 9'h015, 8, 0, 1'b0, 1'b0, -1);
      begin
        repeat (PUSH_SLOT - 1) step();
        check("t6_full_before", cnt_c, 4);
        if_c.m_ready = 1'b1;
      end
    join
    repeat (10) step();
    if_c.m_ready = 1'b0;
    check("t6_no_overrun", pulse_cnt[5] - ov_base, 0);
    check("t6_drained", exp_c.size(), 0);
    check("t6_count", cnt_c, 0);

    check("end_long_pulses", long_pulse, 0);
    check("end_ov_a", pulse_cnt[1], 0);
    check("end_fe_c", pulse_cnt[4], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
